// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder backing a DEPTH x 32-bit register file.
// Handles single-beat Get / PutFullData / PutPartialData on channel A and
// answers on channel D through a 2-entry response queue (latency 1).
// Optional build macro TL_RESP_PROTO_CHECK_EN adds protocol-field checks
// (a_param, alignment, PutFull lane mask, empty Put mask) that deny the request.
module tl_ul_sram_responder #(
  parameter int          DEPTH = 16,
  parameter logic [29:0] BASE  = 30'h0000000,
  parameter int          SRC_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [2:0]       a_param,
  input  logic [1:0]       a_size,
  input  logic [SRC_W-1:0] a_source,
  input  logic [29:0]      a_address,
  input  logic [3:0]       a_mask,
  input  logic [31:0]      a_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [1:0]       d_size,
  output logic [SRC_W-1:0] d_source,
  output logic             d_denied,
  output logic [31:0]      d_data
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]       opcode;
    logic [1:0]       size;
    logic [SRC_W-1:0] source;
    logic             denied;
    logic [31:0]      data;
  } rsp_t;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  rsp_t          rsp_q [2];
  rsp_t          rsp_d [2];
  logic [1:0]    count_q, count_d;
  logic          head_q, head_d;

  logic          a_fire, d_fire;
  logic [29:0]   off;
  logic          in_range, is_get, is_put, size_ok, proto_bad, denied, wr_en;
  logic [AW-1:0] idx;
  rsp_t          rsp_new, rsp_head;
  logic          unused_bits;

  assign a_ready  = reset_n & (count_q < 2'd2);
  assign a_fire   = a_valid & a_ready;
  assign d_valid  = (count_q != 2'd0);
  assign d_fire   = d_valid & d_ready;
  assign rsp_head = rsp_q[head_q];
  assign {d_opcode, d_size, d_source, d_denied, d_data} = d_valid ? rsp_head : '0;

  // Request decode: address window, opcode legality, optional protocol checks
  always_comb begin
    off       = a_address - BASE;
    in_range  = (a_address >= BASE) && (off[29:2] < 28'(DEPTH));
    idx       = off[AW+1:2];
    is_get    = (a_opcode == 3'd4);
    is_put    = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    size_ok   = (a_size != 2'd3);
    proto_bad = 1'b0;
`ifdef TL_RESP_PROTO_CHECK_EN
    begin
      logic [3:0] lanes;
      logic       misaligned;
      case (a_size)
        2'd0:    lanes = 4'b0001 << a_address[1:0];
        2'd1:    lanes = 4'b0011 << a_address[1:0];
        default: lanes = 4'b1111;
      endcase
      misaligned = (a_size == 2'd1 && a_address[0]) ||
                   (a_size == 2'd2 && a_address[1:0] != 2'd0);
      proto_bad  = (a_param != 3'd0) || misaligned ||
                   (a_opcode == 3'd0 && a_mask != lanes) ||
                   (is_put && a_mask == 4'd0);
    end
`endif
    denied = !(is_get || is_put) || !size_ok || !in_range || proto_bad;
    wr_en  = a_fire && is_put && !denied;
    rsp_new.opcode = (is_get && size_ok) ? 3'd1 : 3'd0;
    rsp_new.size   = a_size;
    rsp_new.source = a_source;
    rsp_new.denied = denied;
    rsp_new.data   = (is_get && !denied) ? mem_q[idx] : 32'd0;
  end

  // Without the protocol checks a_param and the low offset bits are don't-care
  assign unused_bits = ^{a_param, off[1:0]};

  // Byte-masked storage update on an accepted, non-denied Put
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (a_mask[b]) mem_d[idx][8*b +: 8] = a_data[8*b +: 8];
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Response queue: push at tail (head + count), pop at head
  always_comb begin
    rsp_d   = rsp_q;
    count_d = count_q + {1'b0, a_fire} - {1'b0, d_fire};
    head_d  = head_q ^ d_fire;
    if (a_fire) rsp_d[head_q ^ count_q[0]] = rsp_new;
  end

  // Queue state; reset drops every pending response
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      rsp_q[0] <= '0;
      rsp_q[1] <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      rsp_q   <= rsp_d;
    end
  end
endmodule
